// File: rtl/qmux_sel_ctrl.sv
// Glitch-free select sequencer for a QMUX clock mux: gates both sources, settles, swaps IS,
// settles again, then enables the new source. Optional `QMUX_SEL_CTRL_LOCK_EN adds a LOCK input.
module qmux_sel_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic QCK,
    input  logic QRT,
`ifdef QMUX_SEL_CTRL_LOCK_EN
    input  logic LOCK,
`endif
    input  logic REQ_VALID,
    input  logic SEL_REQ,
    output logic REQ_READY,
    output logic IS,
    output logic GMUX_EN,
    output logic QHSCK_EN,
    output logic BUSY,
    output logic DONE
);

    typedef enum logic [1:0] {StIdle, StOff, StSwapSettle, StDone} state_e;

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tgt_q, tgt_d;
    logic             is_q, is_d;
    logic             gmux_en_q, gmux_en_d;
    logic             qhsck_en_q, qhsck_en_d;
    logic             done_q, done_d;
    logic             lock;
    logic             req_ready;
    logic             accept;

`ifdef QMUX_SEL_CTRL_LOCK_EN
    assign lock = LOCK;
`else
    assign lock = 1'b0;
`endif

    // LOCK only gates new acceptances; a switch in flight runs to completion.
    assign req_ready = (state_q == StIdle) && !QRT && !lock;
    assign accept    = REQ_VALID && req_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tgt_d      = tgt_q;
        is_d       = is_q;
        gmux_en_d  = gmux_en_q;
        qhsck_en_d = qhsck_en_q;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    tgt_d = SEL_REQ;
                    if (SEL_REQ == is_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        gmux_en_d  = 1'b0;
                        qhsck_en_d = 1'b0;
                        cnt_d      = '0;
                        state_d    = StOff;
                    end
                end
            end
            StOff: begin
                // IS only moves here, while both source gates are closed.
                if (cnt_q == LastCnt) begin
                    is_d    = tgt_q;
                    cnt_d   = '0;
                    state_d = StSwapSettle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StSwapSettle: begin
                if (cnt_q == LastCnt) begin
                    gmux_en_d  = !tgt_q;
                    qhsck_en_d = tgt_q;
                    cnt_d      = '0;
                    done_d     = 1'b1;
                    state_d    = StDone;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge QCK) begin
        if (QRT) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            tgt_q      <= 1'b0;
            is_q       <= 1'b0;
            gmux_en_q  <= 1'b1;
            qhsck_en_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tgt_q      <= tgt_d;
            is_q       <= is_d;
            gmux_en_q  <= gmux_en_d;
            qhsck_en_q <= qhsck_en_d;
            done_q     <= done_d;
        end
    end

    assign REQ_READY = req_ready;
    assign IS        = is_q;
    assign GMUX_EN   = gmux_en_q;
    assign QHSCK_EN  = qhsck_en_q;
    assign BUSY      = (state_q != StIdle);
    assign DONE      = done_q;

endmodule

// File: tb/tb_qmux_sel_ctrl.sv
// Scoreboard bench for qmux_sel_ctrl: per-edge expected output vectors are queued when a
// request is driven and popped as the DUT advances.
module tb_qmux_sel_ctrl;

    localparam int S = 4;

    logic QCK = 1'b0;
    logic QRT = 1'b1;
    logic REQ_VALID = 1'b0;
    logic SEL_REQ = 1'b0;
`ifdef QMUX_SEL_CTRL_LOCK_EN
    logic LOCK = 1'b0;
`endif
    logic REQ_READY, IS, GMUX_EN, QHSCK_EN, BUSY, DONE;

    int n_vec = 0;
    int n_err = 0;
    logic cur_is = 1'b0;
    logic [5:0] exp_q[$];

    always #5 QCK = ~QCK;

    qmux_sel_ctrl #(.SETTLE_CYCLES(S), .CNT_W(8)) dut (
        .QCK       (QCK),
        .QRT       (QRT),
`ifdef QMUX_SEL_CTRL_LOCK_EN
        .LOCK      (LOCK),
`endif
        .REQ_VALID (REQ_VALID),
        .SEL_REQ   (SEL_REQ),
        .REQ_READY (REQ_READY),
        .IS        (IS),
        .GMUX_EN   (GMUX_EN),
        .QHSCK_EN  (QHSCK_EN),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    // Vector layout: {IS, GMUX_EN, QHSCK_EN, BUSY, REQ_READY, DONE}
    function automatic logic [5:0] idle_vec(input logic v);
        return {v, ~v, v, 1'b0, 1'b1, 1'b0};
    endfunction

    // Expected outputs after edge E0+j for a request accepted at E0.
    function automatic logic [5:0] model(input logic cur, input logic tgt, input int j);
        if (tgt == cur) return (j == 0) ? {cur, ~cur, cur, 1'b1, 1'b0, 1'b1} : idle_vec(cur);
        if (j < S) return {cur, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        if (j < 2 * S) return {tgt, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        if (j == 2 * S) return {tgt, ~tgt, tgt, 1'b1, 1'b0, 1'b1};
        return idle_vec(tgt);
    endfunction

    task automatic test_reset();
        logic [5:0] exp, obs;
        QRT = 1'b1;
        REQ_VALID = 1'b0;
        for (int j = 0; j < 5; j++) exp_q.push_back((j < 3) ? 6'b010000 : idle_vec(1'b0));
        for (int j = 0; j < 5; j++) begin
            @(posedge QCK); #1;
            if (j == 2) QRT = 1'b0;
            exp = exp_q.pop_front();
            obs = {IS, GMUX_EN, QHSCK_EN, BUSY, REQ_READY, DONE};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL reset j=%0d got=%b want=%b", j, obs, exp);
            end
        end
        cur_is = 1'b0;
    endtask

    task automatic test_request(input logic tgt, input string name);
        logic [5:0] exp, obs;
        REQ_VALID = 1'b1;
        SEL_REQ = tgt;
        for (int j = 0; j <= 2 * S + 2; j++) exp_q.push_back(model(cur_is, tgt, j));
        for (int j = 0; j <= 2 * S + 2; j++) begin
            @(posedge QCK); #1;
            if (j == 0) REQ_VALID = 1'b0;
            exp = exp_q.pop_front();
            obs = {IS, GMUX_EN, QHSCK_EN, BUSY, REQ_READY, DONE};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL %s j=%0d got=%b want=%b", name, j, obs, exp);
            end
        end
        cur_is = tgt;
    endtask

    task automatic test_ignore_while_busy(input logic tgt);
        logic [5:0] exp, obs;
        int dones = 0;
        REQ_VALID = 1'b1;
        SEL_REQ = tgt;
        for (int j = 0; j <= 2 * S + 2; j++) exp_q.push_back(model(cur_is, tgt, j));
        for (int j = 0; j <= 2 * S + 2; j++) begin
            @(posedge QCK); #1;
            exp = exp_q.pop_front();
            obs = {IS, GMUX_EN, QHSCK_EN, BUSY, REQ_READY, DONE};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL ignore j=%0d got=%b want=%b", j, obs, exp);
            end
            if (DONE === 1'b1) dones++;
            // Keep chattering until the last edge the FSM is still busy.
            if (j < 2 * S) begin
                REQ_VALID = j[0];
                SEL_REQ = ~SEL_REQ;
            end else begin
                REQ_VALID = 1'b0;
            end
        end
        n_vec++;
        if (dones != 1) begin
            n_err++;
            $display("FAIL ignore_done_count got=%0d want=1", dones);
        end
        cur_is = tgt;
    endtask

    task automatic test_reset_mid_switch();
        logic [5:0] exp, obs;
        REQ_VALID = 1'b1;
        SEL_REQ = 1'b1;
        for (int j = 0; j <= 5; j++) exp_q.push_back(model(1'b0, 1'b1, j));
        exp_q.push_back(6'b010000);
        exp_q.push_back(idle_vec(1'b0));
        exp_q.push_back(idle_vec(1'b0));
        for (int j = 0; j <= 8; j++) begin
            @(posedge QCK); #1;
            if (j == 0) REQ_VALID = 1'b0;
            exp = exp_q.pop_front();
            obs = {IS, GMUX_EN, QHSCK_EN, BUSY, REQ_READY, DONE};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL reset_mid j=%0d got=%b want=%b", j, obs, exp);
            end
            if (j == 5) QRT = 1'b1;
            if (j == 6) QRT = 1'b0;
        end
        cur_is = 1'b0;
    endtask

`ifdef QMUX_SEL_CTRL_LOCK_EN
    task automatic test_lock();
        logic [5:0] exp, obs;
        logic tgt;
        tgt = ~cur_is;
        LOCK = 1'b1;
        REQ_VALID = 1'b1;
        SEL_REQ = tgt;
        for (int j = 0; j < 3; j++) exp_q.push_back({cur_is, ~cur_is, cur_is, 3'b000});
        for (int j = 0; j < 3; j++) begin
            @(posedge QCK); #1;
            exp = exp_q.pop_front();
            obs = {IS, GMUX_EN, QHSCK_EN, BUSY, REQ_READY, DONE};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL lock_idle j=%0d got=%b want=%b", j, obs, exp);
            end
        end
        LOCK = 1'b0;
        for (int j = 0; j <= 2 * S; j++) exp_q.push_back(model(cur_is, tgt, j));
        exp_q.push_back(idle_vec(tgt));
        for (int j = 0; j <= 2 * S + 1; j++) begin
            @(posedge QCK); #1;
            if (j == 0) REQ_VALID = 1'b0;
            if (j == 2) LOCK = 1'b1;
            if (j == 2 * S) LOCK = 1'b0;
            exp = exp_q.pop_front();
            obs = {IS, GMUX_EN, QHSCK_EN, BUSY, REQ_READY, DONE};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL lock_mid j=%0d got=%b want=%b", j, obs, exp);
            end
        end
        cur_is = tgt;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_request(1'b0, "same_sel_0");
        test_request(1'b1, "switch_0_to_1");
        test_request(1'b1, "same_sel_1");
        test_request(1'b0, "switch_1_to_0");
        test_ignore_while_busy(1'b1);
        test_request(1'b0, "switch_back_0");
        test_reset_mid_switch();
`ifdef QMUX_SEL_CTRL_LOCK_EN
        test_lock();
`endif
        test_request(1'b1, "after_reset_switch");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/qmux_sel_ctrl.md
QMUX_SEL_CTRL -- requirements
Module: qmux_sel_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, meaning cycles both sources stay gated before and after the select change; legal range 1..255.
REQ-002 SHALL have parameter CNT_W, default 8, meaning settle counter width; SETTLE_CYCLES < 2^CNT_W.
REQ-003 SHALL have port QCK  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port QRT  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port REQ_VALID  input  1  switch request strobe.
REQ-006 SHALL have port SEL_REQ  input  1  requested source: 0 = GMUXIN, 1 = QHSCK.
REQ-007 SHALL have port REQ_READY  output  1  request accepted on an edge where REQ_VALID and REQ_READY are both 1.
REQ-008 SHALL have port IS  output  1  registered select driving the downstream QMUX IS pin.
REQ-009 SHALL have port GMUX_EN  output  1  registered enable for the GMUXIN clock source gate.
REQ-010 SHALL have port QHSCK_EN  output  1  registered enable for the QHSCK clock source gate.
REQ-011 SHALL have port BUSY  output  1  high whenever the state is not IDLE.
REQ-012 SHALL have port DONE  output  1  one-cycle pulse on request completion.

Function
REQ-013 SHALL implement states IDLE, OFF, SWAP_SETTLE and DONE.
REQ-014 SHALL drive REQ_READY = 1 only in IDLE.
REQ-015 On acceptance of SEL_REQ == IS at edge E0: SHALL go to DONE with no change to IS or enables; DONE=1 for the cycle after E0; IDLE again after E0+1.
REQ-016 On acceptance of SEL_REQ != IS at edge E0: SHALL clear GMUX_EN and QHSCK_EN, clear the counter and enter OFF, all after E0.
REQ-017 In OFF, SHALL increment the counter each cycle; at edge E0+SETTLE_CYCLES SHALL load IS with the latched target, clear the counter and enter SWAP_SETTLE.
REQ-018 In SWAP_SETTLE, at edge E0+2*SETTLE_CYCLES SHALL set the enable of the newly selected source to 1 (other enable stays 0) and enter DONE.
REQ-019 DONE SHALL last exactly one cycle with DONE=1, then return to IDLE.
REQ-020 The target SHALL be latched at acceptance; SEL_REQ and REQ_VALID changes while BUSY SHALL be ignored.
REQ-021 Outside OFF/SWAP_SETTLE, exactly one of GMUX_EN/QHSCK_EN SHALL be 1, and it SHALL be GMUX_EN when IS=0 and QHSCK_EN when IS=1.
REQ-022 IS SHALL never change in a cycle where either enable is 1.

Reset
REQ-023 While QRT=1 at an edge: SHALL set state IDLE, IS=0, GMUX_EN=1, QHSCK_EN=0, DONE=0, counter 0, latched target 0, from any state including mid-switch.
REQ-024 REQ_READY SHALL be 0 while QRT=1 and 1 from the first edge after QRT falls (IDLE).

Configuration
REQ-025 Macro QMUX_SEL_CTRL_LOCK_EN defined: SHALL add port LOCK input 1; in IDLE, LOCK=1 forces REQ_READY=0; LOCK SHALL NOT affect a switch already in progress.
REQ-026 Macro QMUX_SEL_CTRL_LOCK_EN undefined: SHALL have no LOCK port; REQ_READY follows REQ-014 only.

Verification
REQ-027 Reset, then no stimulus -> IS=0, GMUX_EN=1, QHSCK_EN=0, BUSY=0, REQ_READY=1, DONE=0.
REQ-028 SETTLE_CYCLES=4, accept SEL_REQ=1 at E0 -> both enables 0 after E0; IS=1 after E0+4; QHSCK_EN=1 and DONE=1 after E0+8; REQ_READY=1 after E0+9.
REQ-029 Accept SEL_REQ=0 while IS=0 -> DONE pulse one cycle after E0; no enable or IS toggle; REQ_READY after E0+1.
REQ-030 QRT=1 at E0+6 of a 0->1 switch -> after that edge IS=0, GMUX_EN=1, QHSCK_EN=0, state IDLE, no DONE pulse.
REQ-031 Toggle SEL_REQ/REQ_VALID every cycle during a switch -> ignored; exactly one DONE; final IS equals target latched at acceptance.
REQ-032 With QMUX_SEL_CTRL_LOCK_EN: LOCK=1 in IDLE with REQ_VALID=1 -> REQ_READY=0, no acceptance; LOCK=1 raised mid-switch -> switch completes with DONE after E0+8.
